// File: rtl/sfx_arbiter_pkg.sv
// Shared constants, state encoding and lookup helpers for the sound-effect arbiter.
package sfx_pkg;

  localparam int SFX_FIRE   = 0;
  localparam int SFX_KILL   = 1;
  localparam int SFX_STAGE  = 2;
  localparam int SFX_SPIDER = 3;

  // Half period in clk25 cycles: 1 kHz, 1.32 kHz, 2 kHz, 500 Hz (entry 0 is rightmost)
  localparam logic [3:0][15:0] HALF_PERIOD = {16'd25000, 16'd6250, 16'd9470, 16'd12500};

  // Effect length in duration ticks
  localparam logic [3:0][7:0] DURATION = {8'd80, 8'd150, 8'd40, 8'd20};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sfx_state_e;

  function automatic logic [15:0] sfx_half_period(input logic [1:0] id);
    return HALF_PERIOD[id];
  endfunction

  function automatic logic [7:0] sfx_duration(input logic [1:0] id);
    return DURATION[id];
  endfunction

endpackage

// File: rtl/sfx_arbiter_if.sv
// Request/speaker bundle between the game controllers and the sound-effect arbiter.
interface sfx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic             bgm_in;
  logic             mute;
  logic             buzz;
  logic             sfx_active;
  logic [IW-1:0]    sfx_id;
  logic             grant;

  modport master (
    output req, bgm_in, mute,
    input  buzz, sfx_active, sfx_id, grant
  );

  modport slave (
    input  req, bgm_in, mute,
    output buzz, sfx_active, sfx_id, grant
  );
endinterface

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: 16-bit half-period counter toggling tone_q, restartable by load.
module sfx_tone_gen (
  input  logic        clk25,
  input  logic        reset,
  input  logic        load,
  input  logic        run,
  input  logic [15:0] half_period,
  output logic        tone_d
);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        tone_q;

  // Next counter/tone value: load restarts high at phase 0, run advances the phase
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (load) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (run) begin
      if (cnt_q >= half_period - 16'd1) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Counter and tone registers
  always_ff @(posedge clk25) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end
endmodule

// File: rtl/sfx_arbiter.sv
// Shares the piezo pin between background music and prioritised, preemptible sound effects.
module sfx_arbiter
  import sfx_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TICK_CYCLES = 25000,
  parameter int GAP_TICKS   = 10
) (
  input  logic          clk25,
  input  logic          reset,
  sfx_arbiter_if.slave  bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]    GAP_END    = 8'(GAP_TICKS);

  sfx_state_e       state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d, clr;
  logic [IW-1:0]    cur_q, cur_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [7:0]       dur_q, dur_d;
  logic [7:0]       gap_q, gap_d;
  logic             bgm_p0, bgm_p1;
  logic             buzz_q, buzz_d;
  logic             grant_q, grant_d;
  logic             active_q, active_d;
  logic [IW-1:0]    id_q;
  logic             win_vld;
  logic [IW-1:0]    win_id;
  logic             start, retrig, tick_wrap;
  logic             tone_d;

  assign tick_wrap = (presc_q == PRESC_LAST);

  // Fixed-priority pick: highest pending index wins
  always_comb begin
    win_vld = |pending_q;
    win_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pending_q[i]) win_id = IW'(i);
    end
  end

  // Next-state logic: arbitration, preemption, retrigger, tick/duration/gap counting
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    presc_d = presc_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    start   = 1'b0;
    retrig  = 1'b0;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = PLAY;
          start   = 1'b1;
          cur_d   = win_id;
          presc_d = '0;
          dur_d   = '0;
        end
      end
      PLAY: begin
        if (win_vld && (win_id > cur_q)) begin
          start   = 1'b1;
          cur_d   = win_id;
          presc_d = '0;
          dur_d   = '0;
        end else if (pending_q[cur_q]) begin
          retrig  = 1'b1;
          presc_d = '0;
          dur_d   = '0;
        end else if (tick_wrap) begin
          presc_d = '0;
          dur_d   = dur_q + 8'd1;
          if (dur_q + 8'd1 >= sfx_duration(2'(cur_q))) begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      GAP: begin
        if (tick_wrap) begin
          presc_d = '0;
          gap_d   = gap_q + 8'd1;
          if (gap_q + 8'd1 >= GAP_END) state_d = IDLE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A request landing on the same edge as its own grant re-queues it
    if (start || retrig) clr[cur_d] = 1'b1;
    pending_d = (pending_q & ~clr) | bus.req;
  end

  // Registered outputs, computed from the state being entered
  always_comb begin
    grant_d  = start | retrig;
    active_d = (state_d == PLAY);
    buzz_d   = 1'b0;
    if (!bus.mute) begin
      case (state_d)
        PLAY:    buzz_d = tone_d;
        GAP:     buzz_d = 1'b0;
        default: buzz_d = bgm_p1;
      endcase
    end
  end

  // State, counters, synchroniser and output registers
  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cur_q     <= '0;
      presc_q   <= '0;
      dur_q     <= '0;
      gap_q     <= '0;
      bgm_p0    <= 1'b0;
      bgm_p1    <= 1'b0;
      buzz_q    <= 1'b0;
      grant_q   <= 1'b0;
      active_q  <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      presc_q   <= presc_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      bgm_p0    <= bus.bgm_in;
      bgm_p1    <= bgm_p0;
      buzz_q    <= buzz_d;
      grant_q   <= grant_d;
      active_q  <= active_d;
      id_q      <= cur_d;
    end
  end

  sfx_tone_gen u_tone (
    .clk25       (clk25),
    .reset       (reset),
    .load        (start),
    .run         ((state_q == PLAY) && !start),
    .half_period (sfx_half_period(2'(cur_q))),
    .tone_d      (tone_d)
  );

  assign bus.buzz       = buzz_q;
  assign bus.grant      = grant_q;
  assign bus.sfx_active = active_q;
  assign bus.sfx_id     = id_q;
endmodule
